// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multi-cycle ARM-subset controller.
// Holds the state encodings, instruction class / func / condition codes and
// the datapath select codes used by the controller and its condition checker.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8
  } state_t;

  // Instruction class (Op)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // func codes
  localparam logic [5:0] F_ADD = 6'b101000;
  localparam logic [5:0] F_SUB = 6'b100100;
  localparam logic [5:0] F_AND = 6'b100000;
  localparam logic [5:0] F_ORR = 6'b111000;
  localparam logic [5:0] F_LSL = 6'b100010;
  localparam logic [5:0] F_LSR = 6'b100110;
  localparam logic [5:0] F_CMP = 6'b100101;
  localparam logic [5:0] F_STR = 6'b011000;
  localparam logic [5:0] F_LDR = 6'b011001;

  // ALU_Control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_CMP = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_ORR = 3'b101;

  // ALU_SrcB select codes
  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result_Src select codes
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Cond codes; every other encoding means "never"
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Data-processing func values that EXECR knows how to execute.
  function automatic logic is_dp_func(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_ORR) ||
           (f == F_LSL) || (f == F_LSR) || (f == F_CMP);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Condition evaluation: decides whether the current instruction may commit.
// Only EQ/NE/AL are supported, so of the NZCV flags only Z is needed.
// Ports:
//   Cond    in  4  condition field from IR
//   z_flag  in  1  registered Z flag (NZCV bit 2)
//   cond_ok out 1  1 = architectural writes allowed
module cond_check
  import multi_cycle_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic       z_flag,
  output logic       cond_ok
);

  always_comb begin
    cond_ok = 1'b0;
    case (Cond)
      COND_EQ: cond_ok = z_flag;
      COND_NE: cond_ok = ~z_flag;
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing the multi-cycle ARM-subset datapath
// (fetch, decode, execute, memory access, writeback) and owning the NZCV
// flag register.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   Op, func, Cond        instruction fields from the IR
//   ALU_Flag              NZCV from the ALU (Z at bit 2)
//   PC_Write, IR_Write, Reg_Write, Mem_Write   write enables
//   Adr_Src, ALU_SrcA, ALU_SrcB, ALU_Control,
//   ALU_Shift_Control, Shift_Select, Result_Src datapath selects
//   Flags                 current NZCV register
//   State                 current state (debug)
//   Illegal               one-cycle pulse in DECODE for unrecognised opcodes
// Contract with the IR: Op/func/Cond are held stable from DECODE until the
// instruction returns to FETCH; this holds because IR_Write is only ever
// asserted in FETCH.
module multi_cycle_controller
  import multi_cycle_pkg::*;
#(
  parameter int         STATE_W     = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         Op,
  input  logic [5:0]         func,
  input  logic [3:0]         Cond,
  input  logic [3:0]         ALU_Flag,
  output logic               PC_Write,
  output logic               IR_Write,
  output logic               Adr_Src,
  output logic               Reg_Write,
  output logic               Mem_Write,
  output logic               ALU_SrcA,
  output logic [1:0]         ALU_SrcB,
  output logic [2:0]         ALU_Control,
  output logic               ALU_Shift_Control,
  output logic               Shift_Select,
  output logic [1:0]         Result_Src,
  output logic [3:0]         Flags,
  output logic [STATE_W-1:0] State,
  output logic               Illegal
);

  state_t     state_q, state_d;
  logic [3:0] flags_q;
  logic       cond_ok;

  // Raw enables before reset gating
  logic pc_write_c, ir_write_c, reg_write_c, mem_write_c, illegal_c;

  cond_check u_cond_check (
    .Cond    (Cond),
    .z_flag  (flags_q[2]),
    .cond_ok (cond_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Only a CMP that passes its own condition updates NZCV, on the edge
  // leaving EXECR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
    end else if (state_q == S_EXECR && func == F_CMP && cond_ok) begin
      flags_q <= ALU_Flag;
    end
  end

  always_comb begin
    state_d           = S_FETCH;
    pc_write_c        = 1'b0;
    ir_write_c        = 1'b0;
    reg_write_c       = 1'b0;
    mem_write_c       = 1'b0;
    illegal_c         = 1'b0;
    Adr_Src           = 1'b0;
    ALU_SrcA          = 1'b0;
    ALU_SrcB          = SRCB_RM;
    ALU_Control       = ALU_ADD;
    ALU_Shift_Control = 1'b0;
    Shift_Select      = 1'b0;
    Result_Src        = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        ALU_SrcA   = 1'b1;
        ALU_SrcB   = SRCB_FOUR;
        Result_Src = RES_ALU;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        if (Op == OP_MEM && (func == F_STR || func == F_LDR)) begin
          state_d = S_MEMADR;
        end else if (Op == OP_DP && is_dp_func(func)) begin
          state_d = S_EXECR;
        end else if (Op == OP_BR) begin
          state_d = S_BRANCH;
        end else begin
          state_d   = S_FETCH;
          illegal_c = 1'b1;
        end
      end
      S_MEMADR: begin
        ALU_SrcB = SRCB_IMM;
        state_d  = (func == F_LDR) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        Adr_Src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        Result_Src  = RES_MEM;
        reg_write_c = cond_ok;
      end
      S_MEMWR: begin
        Adr_Src     = 1'b1;
        mem_write_c = cond_ok;
      end
      S_EXECR: begin
        case (func)
          F_SUB:   ALU_Control = ALU_SUB;
          F_AND:   ALU_Control = ALU_AND;
          F_ORR:   ALU_Control = ALU_ORR;
          F_CMP:   ALU_Control = ALU_CMP;
          F_LSL:   ALU_Shift_Control = 1'b1;
          F_LSR: begin
            ALU_Shift_Control = 1'b1;
            Shift_Select      = 1'b1;
          end
          default: ALU_Control = ALU_ADD;
        endcase
        // CMP has no register result, so it skips ALUWB.
        state_d = (func == F_CMP) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = cond_ok;
      end
      S_BRANCH: begin
        ALU_SrcA   = 1'b1;
        ALU_SrcB   = SRCB_IMM;
        Result_Src = RES_ALU;
        pc_write_c = cond_ok;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset parks the FSM in FETCH, whose enables are active; gating with
  // rst_n keeps every write off for the whole time reset is held.
  assign PC_Write  = pc_write_c  & rst_n;
  assign IR_Write  = ir_write_c  & rst_n;
  assign Reg_Write = reg_write_c & rst_n;
  assign Mem_Write = mem_write_c & rst_n;
  assign Illegal   = illegal_c   & rst_n;

  assign Flags = flags_q;
  assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed testbench for multi_cycle_controller: runs instructions through
// the FSM, checks the state trace against an expected-state queue and checks
// the enables/selects observed in chosen states.
module tb_multi_cycle_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] Op;
  logic [5:0] func;
  logic [3:0] Cond;
  logic [3:0] ALU_Flag;
  logic       PC_Write, IR_Write, Adr_Src, Reg_Write, Mem_Write;
  logic       ALU_SrcA, ALU_Shift_Control, Shift_Select, Illegal;
  logic [1:0] ALU_SrcB, Result_Src;
  logic [2:0] ALU_Control;
  logic [3:0] Flags;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  // Per-cycle observations of the last instruction run
  logic [3:0] o_st[16];
  logic       o_pcw[16], o_irw[16], o_rw[16], o_mw[16], o_adr[16], o_il[16];
  logic       o_sh[16], o_ss[16];
  logic [1:0] o_srcb[16], o_rs[16];
  logic [2:0] o_alu[16];

  multi_cycle_controller #(.STATE_W(4), .RESET_FLAGS(4'b0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Op                (Op),
    .func              (func),
    .Cond              (Cond),
    .ALU_Flag          (ALU_Flag),
    .PC_Write          (PC_Write),
    .IR_Write          (IR_Write),
    .Adr_Src           (Adr_Src),
    .Reg_Write         (Reg_Write),
    .Mem_Write         (Mem_Write),
    .ALU_SrcA          (ALU_SrcA),
    .ALU_SrcB          (ALU_SrcB),
    .ALU_Control       (ALU_Control),
    .ALU_Shift_Control (ALU_Shift_Control),
    .Shift_Select      (Shift_Select),
    .Result_Src        (Result_Src),
    .Flags             (Flags),
    .State             (State),
    .Illegal           (Illegal)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge with the FSM in FETCH. Drives the instruction,
  // then samples len cycles (negedge each), comparing State with exp_q.
  // Returns at a negedge on the last sampled cycle.
  task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] cd, input logic [3:0] fl, input int len);
    Op = op; func = fn; Cond = cd; ALU_Flag = fl;
    for (int i = 0; i < len; i++) begin
      o_st[i] = State;       o_pcw[i] = PC_Write;  o_irw[i] = IR_Write;
      o_rw[i] = Reg_Write;   o_mw[i] = Mem_Write;  o_adr[i] = Adr_Src;
      o_il[i] = Illegal;     o_sh[i] = ALU_Shift_Control;
      o_ss[i] = Shift_Select; o_srcb[i] = ALU_SrcB; o_rs[i] = Result_Src;
      o_alu[i] = ALU_Control;
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
      else check($sformatf("%s_state%0d", tag, i), o_st[i], exp_q.pop_front());
      if (i < len - 1) @(negedge clk);
    end
  endtask

  task automatic push_seq(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [3:0] s3, input logic [3:0] s4, input logic [3:0] s5,
                          input int n);
    logic [3:0] s[6];
    s = '{s0, s1, s2, s3, s4, s5};
    for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
  endtask

  initial begin
    rst_n = 1'b0; Op = 2'b00; func = 6'd0; Cond = 4'b1110; ALU_Flag = 4'd0;
    repeat (3) @(negedge clk);

    // Reset state: FETCH encoding but every enable held off
    check("rst_state", State, 4'd0);
    check("rst_flags", Flags, 4'd0);
    check("rst_enables", {PC_Write, IR_Write, Reg_Write, Mem_Write, Illegal}, 5'b0);

    rst_n = 1'b1;
    #1;
    check("fetch_en", {IR_Write, PC_Write, Adr_Src, ALU_SrcA}, 4'b1101);
    check("fetch_sel", {ALU_SrcB, ALU_Control, Result_Src}, {2'b10, 3'b000, 2'b10});
    @(negedge clk);
    // That edge performed the first fetch; back up so each run starts in FETCH.
    // State is now DECODE with Op=00/func=0 (illegal) -> returns to FETCH.
    check("first_decode", State, 4'd1);
    @(negedge clk);
    check("back_fetch", State, 4'd0);

    // ADD, Cond AL
    push_seq(0, 1, 6, 7, 0, 0, 5);
    run_instr("add", 2'b00, 6'b101000, 4'b1110, 4'b0000, 5);
    check("add_alu", o_alu[2], 3'b000);
    check("add_srcb", {o_srcb[2], o_sh[2]}, 3'b000);
    check("add_rw", {o_rw[0], o_rw[1], o_rw[2], o_rw[3]}, 4'b0001);
    check("add_rs", o_rs[3], 2'b00);

    // LDR
    push_seq(0, 1, 2, 3, 4, 0, 6);
    run_instr("ldr", 2'b01, 6'b011001, 4'b1110, 4'b0000, 6);
    check("ldr_adr_srcb", {o_srcb[2], o_adr[3]}, 3'b011);
    check("ldr_wb", {o_rs[4], o_rw[4]}, 3'b011);
    check("ldr_rw_only_wb", {o_rw[0], o_rw[1], o_rw[2], o_rw[3]}, 4'b0000);

    // STR
    push_seq(0, 1, 2, 5, 0, 0, 5);
    run_instr("str", 2'b01, 6'b011000, 4'b1110, 4'b0000, 5);
    check("str_mw", {o_mw[2], o_mw[3], o_adr[3], o_rw[3]}, 4'b0110);

    // LSR and ORR decode in EXECR
    push_seq(0, 1, 6, 7, 0, 0, 5);
    run_instr("lsr", 2'b00, 6'b100110, 4'b1110, 4'b0000, 5);
    check("lsr_shift", {o_sh[2], o_ss[2]}, 2'b11);
    push_seq(0, 1, 6, 7, 0, 0, 5);
    run_instr("orr", 2'b00, 6'b111000, 4'b1110, 4'b0000, 5);
    check("orr_alu", {o_alu[2], o_sh[2]}, {3'b101, 1'b0});

    // CMP sets Flags=0100, no register write
    push_seq(0, 1, 6, 0, 0, 0, 4);
    run_instr("cmp", 2'b00, 6'b100101, 4'b1110, 4'b0100, 4);
    check("cmp_alu", o_alu[2], 3'b010);
    check("cmp_rw", {o_rw[0], o_rw[1], o_rw[2], o_rw[3]}, 4'b0000);
    check("cmp_flags", Flags, 4'b0100);

    // ADD NE with Z=1: full latency, no write
    push_seq(0, 1, 6, 7, 0, 0, 5);
    run_instr("add_ne", 2'b00, 6'b101000, 4'b0001, 4'b0000, 5);
    check("add_ne_rw", o_rw[3], 1'b0);

    // Branch EQ with Z=1
    push_seq(0, 1, 8, 0, 0, 0, 4);
    run_instr("b_eq", 2'b10, 6'b000000, 4'b0000, 4'b0000, 4);
    check("b_eq_pcw", {o_pcw[1], o_pcw[2]}, 2'b01);
    check("b_eq_sel", {o_srcb[2], o_rs[2]}, {2'b01, 2'b10});

    // CMP NE fails: Flags must keep 0100
    push_seq(0, 1, 6, 0, 0, 0, 4);
    run_instr("cmp_ne", 2'b00, 6'b100101, 4'b0001, 4'b0011, 4);
    check("cmp_ne_flags", Flags, 4'b0100);

    // Branch with a "never" condition
    push_seq(0, 1, 8, 0, 0, 0, 4);
    run_instr("b_nv", 2'b10, 6'b000000, 4'b0010, 4'b0000, 4);
    check("b_nv_pcw", o_pcw[2], 1'b0);

    // Illegal Op=11
    push_seq(0, 1, 0, 0, 0, 0, 3);
    run_instr("ill_op", 2'b11, 6'b101000, 4'b1110, 4'b0000, 3);
    check("ill_pulse", {o_il[0], o_il[1], o_il[2]}, 3'b010);
    check("ill_en", {o_pcw[1], o_irw[1], o_rw[1], o_mw[1]}, 4'b0000);

    // Data-processing with an unknown func is also illegal
    push_seq(0, 1, 0, 0, 0, 0, 3);
    run_instr("ill_fn", 2'b00, 6'b000001, 4'b1110, 4'b0000, 3);
    check("ill_fn_pulse", o_il[1], 1'b1);

    // Reset asserted during MEMWR
    push_seq(0, 1, 2, 5, 0, 0, 4);
    run_instr("str_rst", 2'b01, 6'b011000, 4'b1110, 4'b0000, 4);
    check("pre_rst_mw", Mem_Write, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mw", Mem_Write, 1'b0);
    check("rst_mid_state", State, 4'd0);
    check("rst_mid_flags", Flags, 4'd0);
    check("rst_mid_irw", IR_Write, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_fetch", {State, IR_Write}, {4'd0, 1'b1});
    @(negedge clk);
    check("rel_decode", State, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Moore-style FSM that sequences the multi-cycle version of the ARM-subset datapath: fetch, decode, execute, memory access, writeback.
- Holds the condition flags (NZCV) and gates all architectural writes by the condition field.
- Replaces the combinational single-cycle decoder.
- Sits between the instruction register (which supplies Op/func/Cond) and the shared ALU, shifter, register file and unified memory.

Parameters:
- STATE_W, 4, width of the state encoding and of the State debug port.
- RESET_FLAGS, 4'b0000, value loaded into the flag register on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- func  in  6  function field from IR.
- Cond  in  4  condition field: 0000 EQ, 0001 NE, 1110 AL; any other value is treated as never.
- ALU_Flag  in  4  NZCV from the ALU, with Z at bit 2.
- PC_Write  out  1  PC load enable.
- IR_Write  out  1  IR load enable.
- Adr_Src  out  1  memory address select: 0 = PC, 1 = ALU_Out.
- Reg_Write  out  1  register-file write enable.
- Mem_Write  out  1  memory write enable.
- ALU_SrcA  out  1  ALU A select: 0 = Rn, 1 = PC.
- ALU_SrcB  out  2  ALU B select: 00 = Rm, 01 = immediate, 10 = constant 4.
- ALU_Control  out  3  ALU operation: 000 ADD, 001 SUB, 010 CMP (B-A), 100 AND, 101 ORR.
- ALU_Shift_Control  out  1  1 = result taken from the shifter.
- Shift_Select  out  1  0 = LSL, 1 = LSR.
- Result_Src  out  2  writeback select: 00 = ALU_Out, 01 = memory data, 10 = ALU result direct.
- Flags  out  4  current NZCV register.
- State  out  STATE_W  current state (debug).
- Illegal  out  1  one-cycle pulse in DECODE when the instruction is unrecognised.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = FETCH(0) and Flags = RESET_FLAGS.
  - PC_Write, IR_Write, Reg_Write, Mem_Write and Illegal are forced to 0 for as long as rst_n is low.
  - The first FETCH is performed on the first rising edge after deassertion.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, ALUWB=7, BRANCH=8.
- cond_ok is combinational from Cond and the registered Flags: EQ = Z, NE = !Z, AL = 1, all others = 0.
- Every output not listed for a state is 0 in that state.
- FETCH: IR_Write=1, PC_Write=1, Adr_Src=0, ALU_SrcA=1, ALU_SrcB=10, ALU_Control=000, Result_Src=10. Next state is DECODE.
- DECODE: no enables asserted. Next state is chosen as follows:
  - Op=01 with func 011000 (STR) or 011001 (LDR) -> MEMADR.
  - Op=00 with a recognised func -> EXECR.
  - Op=10 -> BRANCH.
  - Anything else -> FETCH, with Illegal=1.
- MEMADR: ALU_SrcA=0, ALU_SrcB=01, ALU_Control=000. Next state is MEMRD for LDR, MEMWR for STR.
- MEMRD: Adr_Src=1. Next state is MEMWB.
- MEMWB: Result_Src=01, Reg_Write=cond_ok. Next state is FETCH.
- MEMWR: Adr_Src=1, Mem_Write=cond_ok. Next state is FETCH.
- EXECR: ALU_SrcA=0, ALU_SrcB=00. Decode by func:
  - ADD 101000 -> ALU_Control 000.
  - SUB 100100 -> ALU_Control 001.
  - AND 100000 -> ALU_Control 100.
  - ORR 111000 -> ALU_Control 101.
  - LSL 100010 -> ALU_Shift_Control=1, Shift_Select=0.
  - LSR 100110 -> ALU_Shift_Control=1, Shift_Select=1.
  - CMP 100101 -> ALU_Control 010.
  - Next state is FETCH for CMP, ALUWB for all others.
- ALUWB: Result_Src=00, Reg_Write=cond_ok. Next state is FETCH.
- BRANCH: ALU_SrcA=1, ALU_SrcB=01, ALU_Control=000, Result_Src=10, PC_Write=cond_ok. Next state is FETCH.
- Flag update: Flags <= ALU_Flag on the clock edge leaving EXECR, only for CMP and only when cond_ok=1. No other instruction modifies Flags.
- Latency in cycles, FETCH to next FETCH:
  - ALU/shift: 4.
  - CMP: 3.
  - LDR: 5.
  - STR: 4.
  - Branch: 3.
  - Illegal: 2.
  - Latency does not depend on cond_ok; a failed condition only suppresses the write enables.
- Op/func/Cond must be stable from DECODE until the instruction completes; the IR guarantees this because IR_Write is asserted only in FETCH.
- Reset asserted mid-instruction: return to FETCH immediately and drop all enables in the same cycle; no partial write occurs after reset assertion.
- Unused state encodings (9-15): next state is FETCH, all outputs 0.

Decomposition:
- Shared package multi_cycle_pkg holds:
  - State encodings.
  - Op class codes.
  - func codes (ADD/SUB/AND/ORR/LSL/LSR/CMP/STR/LDR).
  - ALU_Control codes.
  - ALU_SrcB and Result_Src select codes.
  - Cond codes.
- One sub-module, cond_check: a combinational function of (Cond, Flags) -> cond_ok, reused later by any pipelined controller.

Test Plan:
- Reset release, then ADD (Op=00, func=101000, Cond=1110) -> state sequence 0,1,6,7,0; Reg_Write=1 only in state 7; ALU_Control=000 in state 6.
- LDR (Op=01, func=011001) -> states 0,1,2,3,4,0; Adr_Src=1 in state 3; Result_Src=01 with Reg_Write=1 in state 4. STR (func=011000) -> 0,1,2,5,0 with Mem_Write=1 in state 5.
- CMP with ALU_Flag=0100 -> states 0,1,6,0; Flags=0100 afterwards; Reg_Write stays 0 throughout.
- Then ADD with Cond=0001 (NE) -> states 0,1,6,7 still traversed but Reg_Write=0 in state 7. Then branch with Cond=0000 (EQ) -> PC_Write=1 in state 8.
- Op=11 -> states 0,1,0; Illegal=1 for exactly one cycle; no write enable asserted.
- rst_n pulled low during MEMWR -> Mem_Write drops to 0 asynchronously; State=0 and Flags=0000; after release the first cycle performs a FETCH with IR_Write=1.
